systolic_array_feed_ctrl: RTL and testbench
===========================================

Name: systolic_array_feed_ctrl

Overview:
Upstream sequencer for one systolic-array input FIFO. Accepts matrix rows from the operand buffer over a valid/ready handshake and loads ARRAY_DIM rows into the FIFO. It then issues 2*ARRAY_DIM-1 shift pulses so the skewed operand wavefront fully traverses the array. Its FIFO-side outputs connect directly to the FIFO modport inputs (load, shift, load_values).

Parameters:
ARRAY_DIM, 4, rows/columns of the square array; rows per tile.
DATA_W, 16, element width (FP16).

Ports:
CLK  input  1  system clock.
nRST  input  1  asynchronous active-low reset.
feed_en  input  1  level enable; controller leaves IDLE only while high.
row_valid  input  1  upstream row available.
row_data  input  DATA_W*ARRAY_DIM  one matrix row; element 0 in bits [DATA_W-1:0].
row_ready  output  1  controller accepts row this cycle.
array_stall  input  1  array back-pressure; freezes feeding.
fifo_load  output  1  FIFO load strobe.
fifo_shift  output  1  FIFO shift strobe.
fifo_load_values  output  DATA_W*ARRAY_DIM  row presented to FIFO.
row_count  output  $clog2(ARRAY_DIM+1)  rows loaded in current tile.
feed_active  output  1  high while in FEED.
feed_done  output  1  one-cycle pulse after the last shift.

Behaviour:
- One clock CLK; asynchronous active-low reset nRST. All state and registered outputs clear immediately on nRST low.
- Reset values: state=IDLE; fifo_load, fifo_load_values, row_count, shift_cnt, feed_done = 0. row_ready, fifo_shift, feed_active = 0, because they decode from state IDLE.
- States: IDLE, LOAD, FEED, DONE.
- IDLE -> LOAD on the next edge when feed_en=1. Otherwise stay in IDLE.
- LOAD:
  - row_ready = 1.
  - A handshake (row_valid & row_ready) registers fifo_load=1 and fifo_load_values=row_data on the next cycle, so load latency is 1 cycle. row_count increments on the same edge.
  - With no handshake, fifo_load=0 and fifo_load_values holds its last value.
  - A handshake while row_count==ARRAY_DIM-1 moves to FEED and resets shift_cnt to 0.
  - array_stall has no effect in LOAD.
- FEED:
  - row_ready = 0. Upstream must hold row_valid/row_data stable; nothing is accepted.
  - feed_active = 1.
  - fifo_shift = (state==FEED) & ~array_stall. This is combinational gating on registered state.
  - shift_cnt increments only on cycles where fifo_shift=1. It holds during stall.
  - When fifo_shift=1 and shift_cnt==2*ARRAY_DIM-2, move to DONE.
- DONE: single cycle; feed_done=1 (registered, asserted the cycle state==DONE). row_count and shift_cnt clear. Next state is LOAD if feed_en=1, else IDLE.
- Deasserting feed_en mid-tile does not abort the tile. feed_en is sampled only in IDLE and DONE.
- fifo_load and fifo_shift are never high in the same cycle. The last fifo_load pulse is the first FEED cycle, and fifo_shift in that cycle is suppressed. Therefore the first shift is the second FEED cycle, and shift_cnt counts only actual shifts.
- Minimum tile latency with no stalls and back-to-back rows: ARRAY_DIM load cycles, plus 2*ARRAY_DIM FEED cycles (1 load-settle + 2*ARRAY_DIM-1 shifts), plus 1 DONE. For ARRAY_DIM=4 this is 13 cycles from the first handshake.
- Counter widths: row_count is $clog2(ARRAY_DIM+1) bits; shift_cnt is $clog2(2*ARRAY_DIM) bits. Neither wraps, because both clear in DONE.
- nRST mid-tile: immediate return to IDLE. Partially loaded rows are discarded (the FIFO is reset by the same nRST).

Decomposition:
- systolic_array_pkg holds:
  - feed_state_t enum (IDLE, LOAD, FEED, DONE);
  - localparam SHIFTS_PER_TILE = 2*ARRAY_DIM-1;
  - a function returning the row_count/shift_cnt widths.
- No sub-module; FSM and both counters live in one file. Top-level wiring instantiates this block next to systolic_array_fifo and connects fifo_* to the FIFO modport.

Test Plan:
1. Reset hold and release, feed_en=0 for 5 cycles -> all outputs 0, state IDLE, row_ready=0.
2. feed_en=1, rows 0x0001_0002_0003_0004 .. 0x000D_000E_000F_0010 presented back-to-back:
   - fifo_load pulses 4 cycles, each one cycle after its handshake, with matching fifo_load_values;
   - row_count counts 1..4;
   - then fifo_shift high for exactly 7 cycles;
   - feed_done pulses once, 13 cycles after the first handshake.
3. array_stall=1 for 3 cycles after the 2nd shift -> fifo_shift=0 during the stall, shift_cnt frozen; total shifts still 7; feed_done delayed by 3 cycles.
4. row_valid gapped (valid every other cycle) -> fifo_load only on handshakes; row_ready stays 1 in LOAD; no extra loads.
5. row_valid held high during FEED -> row_ready=0, no fifo_load. The held row is accepted as row 0 of the next tile in the first LOAD cycle after DONE (feed_en=1).
6. nRST pulsed low during the 4th shift -> outputs clear asynchronously. After release, IDLE; with feed_en=1 a fresh 4-row tile completes with row_count starting at 0.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared types and sizing helpers for the systolic-array operand feed path.
// Holds the feed FSM state encoding, the per-tile shift count, and counter width helpers.
// No logic, no ports.
package systolic_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    DONE = 2'd3
  } feed_state_t;

  localparam int ARRAY_DIM_DEF   = 4;
  // Shifts needed for a skewed wavefront to cross the whole array.
  localparam int SHIFTS_PER_TILE = 2*ARRAY_DIM_DEF-1;

  function automatic int shifts_per_tile(input int dim);
    return 2*dim-1;
  endfunction

  // row_count must represent 0..dim inclusive.
  function automatic int row_cnt_w(input int dim);
    return $clog2(dim+1);
  endfunction

  // shift_cnt must represent 0..2*dim-2 inclusive.
  function automatic int shift_cnt_w(input int dim);
    return $clog2(2*dim);
  endfunction

endpackage

// File: rtl/systolic_array_feed_ctrl.sv
// Sequencer: loads ARRAY_DIM rows into the array input FIFO, then issues 2*ARRAY_DIM-1 shifts.
// Latency: fifo_load one cycle after each handshake; 3*ARRAY_DIM+1 cycles per unstalled tile.
// Backpressure: row_ready only in LOAD; array_stall freezes shifting (and shift_cnt) in FEED.
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   feed_en                   level enable, sampled in IDLE and DONE only
//   row_valid/row_ready/row_data   upstream row handshake (element 0 in the low DATA_W bits)
//   array_stall               array back-pressure
//   fifo_load/fifo_shift/fifo_load_values   strobes and row towards the FIFO modport
//   row_count                 rows loaded in the current tile
//   feed_active               high while in FEED
//   feed_done                 one-cycle pulse in the DONE state
module systolic_array_feed_ctrl
  import systolic_array_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int DATA_W    = 16
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              feed_en,
  input  logic                              row_valid,
  input  logic [DATA_W*ARRAY_DIM-1:0]       row_data,
  output logic                              row_ready,
  input  logic                              array_stall,
  output logic                              fifo_load,
  output logic                              fifo_shift,
  output logic [DATA_W*ARRAY_DIM-1:0]       fifo_load_values,
  output logic [row_cnt_w(ARRAY_DIM)-1:0]   row_count,
  output logic                              feed_active,
  output logic                              feed_done
);

  localparam int RW = row_cnt_w(ARRAY_DIM);
  localparam int SW = shift_cnt_w(ARRAY_DIM);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ARRAY_DIM-1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(shifts_per_tile(ARRAY_DIM)-1);

  feed_state_t                     state_q, state_d;
  logic [RW-1:0]                   row_cnt_q, row_cnt_d;
  logic [SW-1:0]                   shift_cnt_q, shift_cnt_d;
  logic                            load_q, load_d;
  logic [DATA_W*ARRAY_DIM-1:0]     load_val_q, load_val_d;
  logic                            done_q, done_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      shift_cnt_q <= '0;
      load_q      <= 1'b0;
      load_val_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    shift_cnt_d = shift_cnt_q;
    load_d      = 1'b0;
    load_val_d  = load_val_q;
    done_d      = 1'b0;
    row_ready   = 1'b0;
    fifo_shift  = 1'b0;
    feed_active = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (feed_en) state_d = LOAD;
      end

      LOAD: begin
        row_ready = 1'b1;
        if (row_valid) begin
          load_d     = 1'b1;
          load_val_d = row_data;
          row_cnt_d  = row_cnt_q + RW'(1);
          if (row_cnt_q == ROW_LAST) begin
            state_d     = FEED;
            shift_cnt_d = '0;
          end
        end
      end

      FEED: begin
        feed_active = 1'b1;
        // The first FEED cycle carries the last load pulse; load and shift
        // must never coincide, so shifting starts one cycle later.
        fifo_shift  = ~array_stall & ~load_q;
        if (fifo_shift) begin
          shift_cnt_d = shift_cnt_q + SW'(1);
          if (shift_cnt_q == SHIFT_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        row_cnt_d   = '0;
        shift_cnt_d = '0;
        state_d     = feed_en ? LOAD : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign fifo_load        = load_q;
  assign fifo_load_values = load_val_q;
  assign row_count        = row_cnt_q;
  assign feed_done        = done_q;

endmodule

// File: tb/tb_systolic_array_feed_ctrl.sv
// Bench for systolic_array_feed_ctrl (ARRAY_DIM=4, DATA_W=16).
module tb_systolic_array_feed_ctrl;

  localparam int DIM = 4;
  localparam int DW  = 16;
  localparam int RDW = DIM*DW;

  logic           CLK;
  logic           nRST;
  logic           feed_en;
  logic           row_valid;
  logic [RDW-1:0] row_data;
  logic           row_ready;
  logic           array_stall;
  logic           fifo_load;
  logic           fifo_shift;
  logic [RDW-1:0] fifo_load_values;
  logic [2:0]     row_count;
  logic           feed_active;
  logic           feed_done;

  systolic_array_feed_ctrl #(.ARRAY_DIM(DIM), .DATA_W(DW)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .feed_en          (feed_en),
    .row_valid        (row_valid),
    .row_data         (row_data),
    .row_ready        (row_ready),
    .array_stall      (array_stall),
    .fifo_load        (fifo_load),
    .fifo_shift       (fifo_shift),
    .fifo_load_values (fifo_load_values),
    .row_count        (row_count),
    .feed_active      (feed_active),
    .feed_done        (feed_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Row k holds elements 4k+1..4k+4, most significant element first.
  function automatic logic [RDW-1:0] row_val(input int k);
    logic [15:0] e0, e1, e2, e3;
    e3 = 16'(4*k+1); e2 = 16'(4*k+2); e1 = 16'(4*k+3); e0 = 16'(4*k+4);
    return {e3, e2, e1, e0};
  endfunction

  // Scoreboard entry: expected row and the cycle its load pulse must appear.
  typedef struct packed {
    logic [RDW-1:0] d;
    logic [31:0]    c;
  } exp_t;
  exp_t sb_q[$];

  // Per-tile monitor state.
  int tile_hs = 0, tile_first_hs = -1, tile_last_hs = -1;
  int tile_loads = 0, tile_shifts = 0, tile_stalls = 0;
  int mon_done_cyc = -1, mon_done_first = -1;
  logic prev_done = 1'b0;

  always @(negedge CLK) begin
    if (!nRST) begin
      sb_q.delete();
      tile_hs = 0; tile_first_hs = -1; tile_last_hs = -1;
      tile_loads = 0; tile_shifts = 0; tile_stalls = 0;
      prev_done = 1'b0;
    end else begin
      if (row_valid && row_ready) begin
        sb_q.push_back('{d: row_data, c: 32'(cyc + 1)});
        if (tile_hs == 0) tile_first_hs = cyc;
        tile_hs++;
        tile_last_hs = cyc;
      end
      if (fifo_load) begin
        if (sb_q.size() == 0) chk("extra_load", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("load_data", 64'(fifo_load_values), 64'(e.d));
          chk("load_cyc", 64'(cyc), 64'(e.c));
        end
        tile_loads++;
        chk("row_count", 64'(row_count), 64'(tile_loads));
        chk("load_no_shift", 64'(fifo_shift), 64'd0);
      end
      if (fifo_shift) tile_shifts++;
      if (feed_active) chk("ready_in_feed", 64'(row_ready), 64'd0);
      if (feed_active && array_stall && !fifo_load) begin
        chk("stall_no_shift", 64'(fifo_shift), 64'd0);
        tile_stalls++;
      end
      if (feed_done) begin
        chk("done_once", 64'(prev_done), 64'd0);
        chk("tile_shifts", 64'(tile_shifts), 64'd7);
        chk("tile_loads", 64'(tile_loads), 64'd4);
        // Last handshake, 1 load-settle cycle, 7 shifts, stalls, then DONE.
        chk("done_cyc", 64'(cyc), 64'(tile_last_hs + 9 + tile_stalls));
        mon_done_cyc   = cyc;
        mon_done_first = tile_first_hs;
        tile_hs = 0; tile_first_hs = -1; tile_last_hs = -1;
        tile_loads = 0; tile_shifts = 0; tile_stalls = 0;
      end
      prev_done = feed_done;
    end
  end

  task automatic wait_hs();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!row_ready && n < 100);
    if (!row_ready) chk("hs_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic send_tile(input int k0, input bit gap);
    for (int r = 0; r < DIM; r++) begin
      row_valid = 1'b1;
      row_data  = row_val(k0 + r);
      wait_hs();
      if (gap && r < DIM-1) begin
        row_valid = 1'b0;
        @(negedge CLK);
        chk("ready_in_gap", 64'(row_ready), 64'd1);
        @(posedge CLK); #1;
      end
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!feed_done && n < 200);
    if (!feed_done) chk("done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_row_ready"},   64'(row_ready), 64'd0);
    chk({tag, "_fifo_load"},   64'(fifo_load), 64'd0);
    chk({tag, "_fifo_shift"},  64'(fifo_shift), 64'd0);
    chk({tag, "_load_values"}, 64'(fifo_load_values), 64'd0);
    chk({tag, "_row_count"},   64'(row_count), 64'd0);
    chk({tag, "_feed_active"}, 64'(feed_active), 64'd0);
    chk({tag, "_feed_done"},   64'(feed_done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; feed_en = 1'b0; row_valid = 1'b0; row_data = '0; array_stall = 1'b0;

    // 1: reset hold, then 5 idle cycles with feed_en low.
    repeat (2) @(posedge CLK);
    #1 chk_outputs_zero("rst");
    @(posedge CLK); #1 nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("idle_ready", 64'(row_ready), 64'd0);
      chk("idle_active", 64'(feed_active), 64'd0);
      chk("idle_load", 64'(fifo_load), 64'd0);
    end
    @(posedge CLK); #1;

    // 2: back-to-back tile. Handshake cycle counts as cycle 1, so DONE is
    // cycle 13, i.e. 12 cycles after the first handshake.
    feed_en = 1'b1;
    send_tile(0, 1'b0);
    wait_done();
    chk("t2_latency", 64'(mon_done_cyc - mon_done_first), 64'd12);

    // 3: 3-cycle stall right after the 2nd shift.
    send_tile(4, 1'b0);
    begin
      int n;
      n = 0;
      do begin @(negedge CLK); #1; n++; end while (tile_shifts != 2 && n < 100);
      if (tile_shifts != 2) chk("t3_shift2_timeout", 64'd0, 64'd1);
    end
    @(posedge CLK); #1 array_stall = 1'b1;
    repeat (3) @(posedge CLK);
    #1 array_stall = 1'b0;
    wait_done();
    chk("t3_latency", 64'(mon_done_cyc - mon_done_first), 64'd15);

    // 4: gapped valid; 5: row held through FEED becomes next tile's row 0.
    send_tile(8, 1'b1);
    row_valid = 1'b1;
    row_data  = row_val(16);
    wait_done();
    send_tile(16, 1'b0);
    chk("t5_first_hs", 64'(tile_first_hs), 64'(mon_done_cyc + 1));
    wait_done();
    chk("t5_latency", 64'(mon_done_cyc - mon_done_first), 64'd12);

    // 6: reset during the 4th shift, then a fresh tile.
    send_tile(20, 1'b0);
    begin
      int n;
      n = 0;
      do begin @(negedge CLK); #1; n++; end while (tile_shifts != 4 && n < 100);
      if (tile_shifts != 4) chk("t6_shift4_timeout", 64'd0, 64'd1);
    end
    nRST = 1'b0;
    #1 chk_outputs_zero("arst");
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    chk("t6_idle_ready", 64'(row_ready), 64'd0);
    chk("t6_idle_count", 64'(row_count), 64'd0);
    @(posedge CLK); #1;
    send_tile(24, 1'b0);
    wait_done();
    chk("t6_latency", 64'(mon_done_cyc - mon_done_first), 64'd12);

    feed_en = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
